// File: rtl/uart_arb_pkg.sv
// Shared state encoding and sizing helpers for the UART TX round-robin arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_HOLD   = 2'd3
    } arb_state_e;

    localparam logic [1:0] ST_IDLE   = ARB_IDLE;
    localparam logic [1:0] ST_LAUNCH = ARB_LAUNCH;
    localparam logic [1:0] ST_WAIT   = ARB_WAIT;
    localparam logic [1:0] ST_HOLD   = ARB_HOLD;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = cnt_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among N_REQ requesters; a grant is held for a
// whole message (up to last) and a watchdog releases the bus if the transmitter dies.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk_ref,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_dat,
    input  logic [N_REQ-1:0]     i_req_last,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_req_done,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_tx_dat,
    output logic                 o_tx_en,
    input  logic                 i_tx_over,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic [1:0]           dbg_state
);
    import uart_arb_pkg::*;

    // Handshake: a requester holds valid/dat/last stable until it sees its one-cycle
    // ready pulse; ready and o_tx_en rise together, done follows the tx_over pulse.

    localparam int IW = cnt_width(N_REQ);
    localparam int CW = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [CW-1:0]    cnt;
    logic             last_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [7:0]       pick_dat;
    logic             pick_last;
    logic [7:0]       own_dat;
    logic             own_last;
    logic [IW-1:0]    ptr_next;
    logic             cnt_done;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // One-hot muxes for the new pick and for the current owner's next byte.
    always_comb begin
        pick_dat  = '0;
        pick_last = 1'b0;
        own_dat   = '0;
        own_last  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) begin
                pick_dat  = i_req_dat[8*k +: 8];
                pick_last = i_req_last[k];
            end
            if (o_grant[k]) begin
                own_dat  = i_req_dat[8*k +: 8];
                own_last = i_req_last[k];
            end
        end
    end

    assign ptr_next  = (owner == IDX_LAST) ? '0 : owner + IW'(1);
    assign cnt_done  = (cnt == CNT_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            o_req_ready <= '0;
            o_req_done  <= '0;
            o_grant     <= '0;
            o_tx_dat    <= '0;
            o_tx_en     <= 1'b0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_tx_en     <= 1'b0;
            o_req_ready <= '0;
            o_req_done  <= '0;
            o_timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner       <= pick_idx;
                        o_grant     <= pick_grant;
                        o_tx_dat    <= pick_dat;
                        last_q      <= pick_last;
                        o_req_ready <= pick_grant;
                        o_tx_en     <= 1'b1;
                        o_busy      <= 1'b1;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion beats the watchdog when both land in the same cycle.
                    if (i_tx_over) begin
                        o_req_done <= o_grant;
                        if (last_q) begin
                            o_grant <= '0;
                            rr_ptr  <= ptr_next;
                            o_busy  <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end
                    end else if (cnt_done) begin
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        rr_ptr    <= ptr_next;
                        o_busy    <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (|(i_req_valid & o_grant)) begin
                        o_tx_dat    <= own_dat;
                        last_q      <= own_last;
                        o_req_ready <= o_grant;
                        o_tx_en     <= 1'b1;
                        state       <= ST_LAUNCH;
                    end else if (cnt_done) begin
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        rr_ptr    <= ptr_next;
                        o_busy    <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: picker vector table, directed corner
// sequences and a randomized multi-message run against a message-level model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk_ref = 1'b0;
    logic             rst;
    logic [N-1:0]     i_req_valid;
    logic [8*N-1:0]   i_req_dat;
    logic [N-1:0]     i_req_last;
    logic [N-1:0]     o_req_ready;
    logic [N-1:0]     o_req_done;
    logic [N-1:0]     o_grant;
    logic [7:0]       o_tx_dat;
    logic             o_tx_en;
    logic             i_tx_over;
    logic             o_busy;
    logic             o_timeout;
    logic [1:0]       dbg_state;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_ref     (clk_ref),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_dat   (i_req_dat),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_req_done  (o_req_done),
        .o_grant     (o_grant),
        .o_tx_dat    (o_tx_dat),
        .o_tx_en     (o_tx_en),
        .i_tx_over   (i_tx_over),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_ref = ~clk_ref;

    initial begin
        #500_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        i_req_valid = '0;
        i_req_dat   = '0;
        i_req_last  = '0;
        i_tx_over   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
        i_req_valid[k]      = v;
        i_req_dat[8*k +: 8] = d;
        i_req_last[k]       = l;
    endtask

    task automatic wait_tx_en(input string name);
        int n = 0;
        tick();
        while (!o_tx_en && n < 64) begin
            tick();
            n++;
        end
        if (!o_tx_en) chk({name, "_tx_en_seen"}, 32'd0, 32'd1);
    endtask

    // Called in the LAUNCH cycle: step into WAIT, then finish the byte.
    task automatic give_over();
        tick();
        i_tx_over = 1'b1;
        tick();
        i_tx_over = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         prev;
        logic [3:0] mask;
        logic [3:0] exp_grant;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t vecs[8];

    // ---------------- random-phase state and scoreboard ----------------
    logic [8:0] rb [N][16];
    int         rcnt [N];
    int         rpos [N];
    int         rgap [N];
    logic [9:0] exp_q [$];
    logic [3:0] done_q [$];

    task automatic drive_random();
        for (int k = 0; k < N; k++) begin
            if (rgap[k] > 0) begin
                i_req_valid[k] = 1'b0;
                rgap[k]--;
            end else begin
                i_req_valid[k] = (rpos[k] < rcnt[k]);
            end
            i_req_dat[8*k +: 8] = rb[k][rpos[k]][7:0];
            i_req_last[k]       = rb[k][rpos[k]][8];
        end
    endtask

    initial begin
        int         n;
        int         stray_bad;
        logic       done_seen;
        logic [3:0] fair_exp [3];
        int         fair_k [3];
        logic [7:0] lk [3];
        logic [3:0] cur_exp;
        logic [9:0] e;
        int         tx_timer;
        logic       finished;
        int         mpos [N];
        int         ptr;
        int         found;
        logic       l;

        vecs[0] = '{1, 4'b0001, 4'b0001, 8'hA0};
        vecs[1] = '{1, 4'b0110, 4'b0100, 8'hA2};
        vecs[2] = '{3, 4'b1010, 4'b0010, 8'hA1};
        vecs[3] = '{2, 4'b1001, 4'b1000, 8'hA3};
        vecs[4] = '{0, 4'b1111, 4'b0010, 8'hA1};
        vecs[5] = '{3, 4'b1000, 4'b1000, 8'hA3};
        vecs[6] = '{2, 4'b0111, 4'b0001, 8'hA0};
        vecs[7] = '{0, 4'b0101, 4'b0100, 8'hA2};

        // Reset state
        do_reset();
        chk("reset_outputs",
            {o_grant, o_tx_en, o_req_ready, o_req_done, o_busy, o_timeout, o_tx_dat, dbg_state}, 32'd0);

        // Single byte from requester 1
        set_req(1, 1'b1, 8'h5A, 1'b1);
        tick();
        chk("single_ready", o_req_ready, 4'b0010);
        chk("single_tx_en", o_tx_en, 1);
        chk("single_dat", o_tx_dat, 8'h5A);
        chk("single_grant", o_grant, 4'b0010);
        set_req(1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("single_tx_en_width", o_tx_en, 0);
        i_tx_over = 1'b1;
        tick();
        i_tx_over = 1'b0;
        chk("single_done", o_req_done, 4'b0010);
        chk("single_released", {o_busy, dbg_state, o_grant}, 0);
        set_req(0, 1'b1, 8'h01, 1'b1);
        set_req(3, 1'b1, 8'h03, 1'b1);
        wait_tx_en("single_next");
        chk("single_ptr_next", o_grant, 4'b1000);
        do_reset();

        // Fairness: 0, 2, 3 twice with pointer wrap
        fair_exp = '{4'b0001, 4'b0100, 4'b1000};
        fair_k   = '{0, 2, 3};
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 3; s++) set_req(fair_k[s], 1'b1, 8'(8'h10 + fair_k[s]), 1'b1);
            for (int s = 0; s < 3; s++) begin
                wait_tx_en("fair");
                chk($sformatf("fair_r%0d_s%0d_grant", r, s), o_grant, fair_exp[s]);
                set_req(fair_k[s], 1'b0, 8'h00, 1'b0);
                give_over();
            end
        end

        // Locked message: req2 sends 3 bytes while req0 waits
        do_reset();
        lk = '{8'h11, 8'h22, 8'h33};
        set_req(2, 1'b1, lk[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_tx_en("lock");
            chk($sformatf("lock_dat%0d", i), o_tx_dat, lk[i]);
            chk($sformatf("lock_grant%0d", i), o_grant, 4'b0100);
            if (i < 2) set_req(2, 1'b1, lk[i+1], (i == 1));
            else       set_req(2, 1'b0, 8'h00, 1'b0);
            if (i == 0) set_req(0, 1'b1, 8'h99, 1'b1);
            give_over();
        end
        wait_tx_en("lock_req0");
        chk("lock_then_req0_grant", o_grant, 4'b0001);
        chk("lock_then_req0_dat", o_tx_dat, 8'h99);
        set_req(0, 1'b0, 8'h00, 1'b0);
        give_over();

        // WAIT timeout: no tx_over for req3
        do_reset();
        set_req(3, 1'b1, 8'h77, 1'b1);
        wait_tx_en("wait_to");
        set_req(3, 1'b0, 8'h00, 1'b0);
        n = 0;
        done_seen = 1'b0;
        while (!o_timeout && n < 40) begin
            tick();
            n++;
            if (o_req_done != 0) done_seen = 1'b1;
        end
        chk("wait_to_latency", n, TO + 1);
        chk("wait_to_grant", o_grant, 0);
        chk("wait_to_no_done", done_seen, 0);
        tick();
        chk("wait_to_pulse_width", o_timeout, 0);

        // tx_over on the final watchdog cycle wins
        set_req(1, 1'b1, 8'h44, 1'b1);
        wait_tx_en("edge");
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (TO) tick();
        i_tx_over = 1'b1;
        tick();
        i_tx_over = 1'b0;
        chk("edge_done", o_req_done, 4'b0010);
        chk("edge_no_timeout", o_timeout, 0);
        tick();
        chk("edge_no_late_timeout", o_timeout, 0);

        // Stray tx_over while idle
        stray_bad = 0;
        for (int i = 0; i < 4; i++) begin
            i_tx_over = 1'b1;
            tick();
            i_tx_over = 1'b0;
            if ({o_req_done, o_timeout, o_busy, o_tx_en} != 0) stray_bad++;
            tick();
        end
        chk("stray_over_idle", stray_bad, 0);

        // HOLD timeout: owner stalls without last
        set_req(0, 1'b1, 8'h55, 1'b0);
        wait_tx_en("hold");
        set_req(0, 1'b0, 8'h00, 1'b0);
        give_over();
        chk("hold_done", o_req_done, 4'b0001);
        chk("hold_busy", o_busy, 1);
        n = 0;
        while (!o_timeout && n < 40) begin
            tick();
            n++;
        end
        chk("hold_to_latency", n, TO);
        chk("hold_to_grant", o_grant, 0);
        chk("hold_to_idle", dbg_state, 0);

        // Reset mid-WAIT; pointer must restart at 0
        set_req(2, 1'b1, 8'h66, 1'b1);
        wait_tx_en("rst_mid");
        set_req(2, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs",
            {o_grant, o_tx_en, o_req_ready, o_req_done, o_busy, o_timeout, o_tx_dat, dbg_state}, 32'd0);
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 8'(8'hC0 + k), 1'b1);
        wait_tx_en("rst_restart");
        chk("rst_restart_grant", o_grant, 4'b0001);

        // Picker table: prev message sets the pointer, then the mask is raised
        for (int v = 0; v < 8; v++) begin
            do_reset();
            set_req(vecs[v].prev, 1'b1, 8'(8'hA0 + vecs[v].prev), 1'b1);
            wait_tx_en("vec_prev");
            set_req(vecs[v].prev, 1'b0, 8'h00, 1'b0);
            give_over();
            for (int k = 0; k < N; k++)
                if (vecs[v].mask[k]) set_req(k, 1'b1, 8'(8'hA0 + k), 1'b1);
            wait_tx_en("vec");
            chk($sformatf("vec%0d_grant", v), o_grant, vecs[v].exp_grant);
            chk($sformatf("vec%0d_dat", v), o_tx_dat, vecs[v].exp_dat);
            chk($sformatf("vec%0d_ready", v), o_req_ready, vecs[v].exp_grant);
        end

        // Randomized messages against a message-level round-robin model
        do_reset();
        for (int k = 0; k < N; k++) begin
            int nm;
            rcnt[k] = 0;
            rpos[k] = 0;
            rgap[k] = 0;
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) begin
                int len;
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) begin
                    l = (b == len - 1);
                    rb[k][rcnt[k]] = {l, 8'($urandom)};
                    rcnt[k]++;
                end
            end
            rb[k][rcnt[k]] = 9'h000;
        end
        for (int k = 0; k < N; k++) mpos[k] = 0;
        ptr = 0;
        found = 0;
        while (found >= 0) begin
            found = -1;
            for (int i = 0; i < N; i++) begin
                int j;
                j = (ptr + i) % N;
                if (found < 0 && mpos[j] < rcnt[j]) found = j;
            end
            if (found >= 0) begin
                l = 1'b0;
                while (!l) begin
                    exp_q.push_back({2'(found), rb[found][mpos[found]][7:0]});
                    l = rb[found][mpos[found]][8];
                    mpos[found]++;
                end
                ptr = (found + 1) % N;
            end
        end

        tx_timer = 0;
        cur_exp  = '0;
        finished = 1'b0;
        drive_random();
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            tick();
            if (o_tx_en) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_tx_en", o_tx_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    cur_exp = 4'b0001 << e[9:8];
                    chk("rnd_grant", o_grant, cur_exp);
                    chk("rnd_ready", o_req_ready, cur_exp);
                    chk("rnd_dat", o_tx_dat, e[7:0]);
                end
            end else if (o_req_ready != 0) begin
                chk("rnd_ready_without_tx_en", o_req_ready, 0);
            end
            if (o_req_done != 0) begin
                if (done_q.size() == 0) chk("rnd_done_unexpected", o_req_done, 0);
                else                    chk("rnd_done", o_req_done, done_q.pop_front());
            end
            if (o_timeout) chk("rnd_no_timeout", o_timeout, 0);
            for (int k = 0; k < N; k++) begin
                if (o_req_ready[k]) begin
                    l = rb[k][rpos[k]][8];
                    rpos[k]++;
                    rgap[k] = l ? 0 : $urandom_range(0, 3);
                end
            end
            i_tx_over = 1'b0;
            if (tx_timer > 0) begin
                tx_timer--;
                if (tx_timer == 0) begin
                    i_tx_over = 1'b1;
                    done_q.push_back(cur_exp);
                end
            end
            if (o_tx_en) tx_timer = $urandom_range(1, 6);
            drive_random();
            finished = (exp_q.size() == 0) && (done_q.size() == 0) && (tx_timer == 0)
                       && !o_busy && !i_tx_over;
            for (int k = 0; k < N; k++)
                if (rpos[k] != rcnt[k]) finished = 1'b0;
        end
        chk("rnd_completed", finished, 1);
        chk("rnd_exp_left", exp_q.size(), 0);
        chk("rnd_done_left", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single RS-232 byte transmitter among N_REQ requesters. It accepts bytes from the requesters and drives the transmitter's start pulse and data. It waits for the byte-complete pulse and keeps the grant for one requester until that requester's message (terminated by `last`) has been sent. It sits between the application logic and the UART top-level TX port; a timeout watchdog stops a dead transmitter from locking the bus.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥1)
- TIMEOUT_CYC, 1_000_000, max cycles in WAIT or HOLD before forced release (≥2)

Ports:
- clk_ref  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- i_req_valid  in  N_REQ  requester k has a byte
- i_req_dat  in  8*N_REQ  byte of requester k at bits [8k+7:8k]
- i_req_last  in  N_REQ  byte is the last of requester k's message
- o_req_ready  out  N_REQ  one-cycle pulse: byte of k consumed
- o_req_done  out  N_REQ  one-cycle pulse: byte of k fully transmitted
- o_grant  out  N_REQ  one-hot current owner, 0 when none
- o_tx_dat  out  8  byte to transmitter
- o_tx_en  out  1  one-cycle transmit start pulse
- i_tx_over  in  1  one-cycle pulse from transmitter: byte finished
- o_busy  out  1  high in any state except IDLE
- o_timeout  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE, LAUNCH, WAIT, HOLD. All outputs are registered.
- IDLE: if any i_req_valid is set, select owner k as the first set bit searching upward from rr_ptr with wrap. Then latch o_grant=onehot(k), o_tx_dat=dat[k] and last_q=last[k], and pulse o_req_ready[k]. Go to LAUNCH.
- LAUNCH: assert o_tx_en for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: count cycles.
  - On i_tx_over: pulse o_req_done[k] the next cycle. If last_q, release; otherwise go to HOLD and clear the counter.
  - If the counter reaches TIMEOUT_CYC-1: pulse o_timeout and release.
- HOLD: count cycles.
  - If i_req_valid[k]: latch dat/last, pulse o_req_ready[k], go to LAUNCH. Other requesters are ignored.
  - On counter reaching TIMEOUT_CYC-1: pulse o_timeout and release.
- Release: o_grant←0, rr_ptr←(k+1) mod N_REQ, go to IDLE.
- o_tx_dat holds its value from LAUNCH until the next latch.
- Requesters hold valid, dat and last stable until they see ready.
- i_tx_over in IDLE, LAUNCH or HOLD is ignored.
- i_tx_over and timeout in the same WAIT cycle: i_tx_over wins, with no o_timeout.
- Reset at any state: state=IDLE, rr_ptr=0, counter=0, all outputs 0. A pending o_tx_en or done pulse is dropped.

## Timing
- Valid sampled in IDLE at cycle T: o_grant, o_tx_dat and o_req_ready are visible in T+1, together with o_tx_en (LAUNCH).
- i_tx_over at cycle W: o_req_done in W+1, with state IDLE or HOLD in W+1.
- From HOLD, valid[k] sampled at H: ready and o_tx_en are in H+1.
- Minimum gap between o_tx_en pulses is 3 cycles plus the transmitter byte time.
- Message from a new requester: at least 1 IDLE cycle follows each release.
- Watchdog: o_timeout appears exactly TIMEOUT_CYC cycles after entering WAIT or HOLD if no progress occurs.
- The counter width is clog2(TIMEOUT_CYC). The counter saturates and never wraps.

## Structure
- Package uart_arb_pkg: state enum (IDLE, LAUNCH, WAIT, HOLD) and the counter-width function.
- Sub-module uart_rr_pick: combinational round-robin picker. Inputs are req[N_REQ] and ptr; outputs are a one-hot grant and an index. It has no state; rr_ptr lives in the arbiter.

## Test plan
- Single byte: N_REQ=4. Req1 sends 0x5A with last=1 → ready[1] and o_tx_en in the same cycle, o_tx_dat=0x5A, o_grant=0010. After i_tx_over: done[1], then IDLE and rr_ptr=2.
- Fairness: req0, req2 and req3 each send a single-byte message, all valid from reset → service order 0, 2, 3. Re-raise all and repeat → order 0, 2, 3 again, with pointer wrap verified.
- Locked message: req2 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33) while req0 stays valid → o_tx_dat sequence is 11, 22, 33, and only then is req0 granted.
- WAIT timeout: TIMEOUT_CYC=16, req3 sends a byte, i_tx_over never arrives → o_timeout exactly 16 cycles after LAUNCH+1, o_grant=0, no done[3].
- Boundary events:
  - i_tx_over on the final watchdog cycle → done and no timeout.
  - Stray i_tx_over in IDLE → no effect.
  - HOLD timeout when the owner stalls without last → release plus o_timeout.
- Reset mid-WAIT: assert rst for 1 cycle → all outputs 0 and next grant starts from index 0.
